pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the instruction memory in the single-cycle MIPS core.
- Holds the PC and drives IAddr/nRD into instruction memory.
- Computes the next PC from sequential, branch, jump and jr sources.
- Watches the returned instruction word for the halt opcode and checks every new PC for misalignment or out-of-range addresses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 240, instruction memory size in bytes; highest legal fetch address is IMEM_BYTES-4.
- HALT_OP, 6'b111111, opcode (instr[31:26]) that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- stall  input  1  1 = hold PC this cycle.
- pc_src  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr.
- ext_imm  input  32  sign-extended branch offset, in words.
- jump_target  input  26  J-type target field.
- jr_addr  input  32  register value for jr.
- IDataOut  input  32  instruction word returned by instruction memory.
- IAddr  output  32  current PC, the fetch address.
- nRD  output  1  active-low read enable to instruction memory.
- pc_plus4  output  32  PC+4, combinational, used for jal link.
- halted  output  1  1 while in HALT.
- fault  output  1  1 while in FAULT.
- fsm_state  output  2  00 BOOT, 01 RUN, 10 HALT, 11 FAULT.
- fetch_cnt  output  32  fetch counter (see Optional Feature).

Behaviour:
- Reset (nReset=0, asynchronous): PC=RESET_PC, state=BOOT, nRD=1, halted=0, fault=0, fetch_cnt=0. Reset asserted mid-operation overrides every state immediately, with no waiting for a clock edge.
- IAddr always equals the PC register. nRD=0 only in RUN; otherwise 1.
- BOOT: first rising edge after reset release moves to RUN; PC unchanged. This gives exactly one idle cycle.
- RUN, next-PC candidate by pc_src:
  - 00: PC+4
  - 01: PC+4+(ext_imm<<2)
  - 10: {pc_plus4[31:28], jump_target, 2'b00}
  - 11: jr_addr
- All arithmetic is modulo 2^32; wrap-around is not flagged by itself but is caught by the range check.
- RUN priority at each edge, highest first:
  1. IDataOut[31:26]==HALT_OP -> state=HALT; PC keeps the halt instruction's address. pc_src and stall are ignored.
  2. stall=1 -> PC held, state stays RUN, no fault check.
  3. Candidate[1:0]!=0 or candidate > IMEM_BYTES-4 -> state=FAULT; PC held at the offending instruction's address (the candidate is not loaded).
  4. Otherwise PC=candidate.
- A branch or jump to the current PC (self-loop) is legal and repeats indefinitely.
- HALT and FAULT are terminal. PC is frozen and inputs are ignored; only nReset exits.
- halted=1 in HALT, fault=1 in FAULT; both are registered and change only with state.
- pc_plus4 is valid in every state.

Optional Feature:
- Macro: PC_FETCH_CNT_EN.
- Defined: fetch_cnt is a 32-bit register, cleared on reset. It increments on every RUN edge where PC is loaded with a new value (priority case 4 only). It freezes in HALT/FAULT and wraps from 32'hFFFF_FFFF to 0.
- Undefined: no counter register is built; fetch_cnt is tied to 32'h0. The port list is identical in both builds.

Test Plan:
- Reset/boot: hold nReset=0 for 3 cycles, release, pc_src=00, no halt word -> IAddr=0 and nRD=1 for one cycle. Then nRD=0 and IAddr steps 0,4,8,12 on successive edges.
- Branch/jump/jr: at PC=8, pc_src=01, ext_imm=32'hFFFF_FFFE -> PC=4. Then pc_src=10, jump_target=26'h000000A -> PC=40. Then pc_src=11, jr_addr=32'h10 -> PC=16.
- Stall and async reset: at PC=12, stall=1 for 3 edges -> IAddr stays 12. Pulse nReset low between edges -> IAddr=0 and fsm_state=00 without waiting for a clock edge.
- Halt: IDataOut=32'hFC00_0000 at PC=20 with pc_src=01 and stall=1 -> next edge halted=1, fsm_state=10, nRD=1, IAddr stays 20 for 10 further cycles.
- Fault: at PC=4, pc_src=11, jr_addr=32'h6 -> fault=1, IAddr=4. Separately, at PC=232, pc_src=00 -> PC=236 legal; next edge (candidate 240) -> fault=1, IAddr=236.
- Counter (PC_FETCH_CNT_EN): 5 advancing edges, 2 stalled edges, then halt -> fetch_cnt=5 and stays 5. Without the macro, fetch_cnt=0 throughout.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the PC stage (master) and the instruction memory (slave).
interface pc_fetch_unit_if;
    logic [31:0] IAddr;
    logic        nRD;
    logic [31:0] IDataOut;

    modport master (output IAddr, output nRD, input IDataOut);
    modport slave  (input IAddr, input nRD, output IDataOut);
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch stage: holds the PC, selects the next PC, and stops on halt or bad fetch addresses.
// Optional fetch counter is built only when PC_FETCH_CNT_EN is defined; otherwise fetch_cnt is tied to zero.
//
// state | meaning
// BOOT  | one idle cycle after reset, nRD high
// RUN   | fetching, PC advances unless stalled
// HALT  | halt opcode seen, PC frozen
// FAULT | misaligned or out-of-range next PC, PC frozen
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 240,
    parameter logic [5:0]  HALT_OP    = 6'b111111
) (
    input  logic              clk,
    input  logic              nReset,
    pc_fetch_unit_if.master   imem,
    input  logic              stall,
    input  logic [1:0]        pc_src,
    input  logic [31:0]       ext_imm,
    input  logic [25:0]       jump_target,
    input  logic [31:0]       jr_addr,
    output logic [31:0]       pc_plus4,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fsm_state,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        HALT  = 2'b10,
        FAULT = 2'b11
    } state_t;

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_nrd;
    logic        r_halted;
    logic        r_fault;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_cand;
    logic        w_halt_op;
    logic        w_bad;
    logic        w_load;
    logic        w_unused_idata;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_halt_op      = (imem.IDataOut[31:26] == HALT_OP);
    assign w_unused_idata = ^imem.IDataOut[25:0];

    always_comb begin
        w_cand = w_pc_plus4;
        case (pc_src)
            2'b00: w_cand = w_pc_plus4;
            2'b01: w_cand = w_pc_plus4 + {ext_imm[29:0], 2'b00};
            2'b10: w_cand = {w_pc_plus4[31:28], jump_target, 2'b00};
            2'b11: w_cand = jr_addr;
            default: w_cand = w_pc_plus4;
        endcase
    end

    // Wrapped arithmetic lands either misaligned or above LAST_PC, so one compare covers it.
    assign w_bad  = (w_cand[1:0] != 2'b00) || (w_cand > LAST_PC);
    assign w_load = (r_state == RUN) && !w_halt_op && !stall && !w_bad;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state  <= BOOT;
            r_pc     <= RESET_PC;
            r_nrd    <= 1'b1;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_nrd   <= 1'b0;
                end
                RUN: begin
                    if (w_halt_op) begin
                        r_state  <= HALT;
                        r_nrd    <= 1'b1;
                        r_halted <= 1'b1;
                    end else if (w_load) begin
                        r_pc <= w_cand;
                    end else if (!stall) begin
                        r_state <= FAULT;
                        r_nrd   <= 1'b1;
                        r_fault <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

`ifdef PC_FETCH_CNT_EN
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_fetch_cnt <= 32'h0;
        end else if (w_load) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`else
    assign fetch_cnt = 32'h0;
`endif

    assign imem.IAddr = r_pc;
    assign imem.nRD   = r_nrd;
    assign pc_plus4   = w_pc_plus4;
    assign halted     = r_halted;
    assign fault      = r_fault;
    assign fsm_state  = r_state;

endmodule
